vga_fb_scan_reader: RTL and testbench
=====================================

// Module: vga_fb_scan_reader
// PURPOSE
//  Read side of the VGA framebuffer: generates 640x480@60 timing from the 50 MHz system clock,
//  scans the 80x60 x 8-bit framebuffer (8x8 screen pixels per cell) through its synchronous
//  read port, and drives RGB 3:3:2 plus HS/VS. Mirrors the MCU port-write path (WA={Y[5:0],X[6:0]}, WD).
// PARAMETERS
//  H_VIS 640 visible px/line; H_FP 16; H_SYNC 96; H_BP 48 (line = 800 px)
//  V_VIS 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33 (frame = 525 lines)
//  CELL_SHIFT 3 log2 screen pixels per framebuffer cell (80x60 cells)
// PORTS
//  CLK          in   1   50 MHz system clock, all state on rising edge
//  RESET_N      in   1   asynchronous, active-low reset
//  RA           out  13  framebuffer read address {Y[5:0],X[6:0]}
//  RD           in   8   framebuffer read data, valid 1 CLK after RA (synchronous RAM)
//  ROUT         out  3   red   = RD[7:5]
//  GOUT         out  3   green = RD[4:2]
//  BOUT         out  2   blue  = RD[1:0]
//  HS           out  1   horizontal sync, active low
//  VS           out  1   vertical sync, active low
//  FRAME_START  out  1   one-CLK pulse when scan returns to (h=0,v=0)
// BEHAVIOUR
//  - Reset (async, RESET_N=0): phase=0, hcnt=0, vcnt=0, RA=0, RGB=0, HS=1, VS=1, FRAME_START=0.
//    Release mid-frame restarts cleanly at (0,0); no partial-line output.
//  - Pixel tick: 1-bit phase toggles each CLK; tick = (phase==1) -> 25 MHz, 1 tick per 2 CLK.
//  - Counters advance only on tick: hcnt 0..799 wraps to 0 and increments vcnt; vcnt 0..524 wraps to 0.
//    hcnt=799,vcnt=524 tick -> both 0 and FRAME_START=1 for that single CLK.
//  - Address (registered on tick, from next counter values): active = h<640 && v<480;
//    RA = active ? {v[8:3], h[9:3]} : 13'h0. X field 0..79, Y field 0..59; never out of range.
//  - RAM returns RD one CLK later; RD is sampled at the following tick (2 CLK after RA update).
//  - Output stage (registered on tick), 1-pixel latency: RGB = active_d ? RD split : 0;
//    HS = ~(656 <= h_d < 752); VS = ~(490 <= v_d < 492); h_d/v_d/active_d = counters delayed 1 tick
//    so RGB, HS, VS stay mutually aligned.
//  - Blanking: RGB forced 0 for whole front porch, sync and back porch, both axes.
//  - Outputs change only on tick edges (or async reset); stable for 2 CLK each.
//  - Timing totals: line = 1600 CLK; HS low 192 CLK/line; frame = 840000 CLK; VS low 2 lines = 3200 CLK.
// TESTING
//  T1 reset: hold RESET_N=0 10 CLK -> HS=VS=1, RGB=0, RA=0; release -> first HS fall at CLK 1314
//     after release (tick 657), low exactly 192 CLK.
//  T2 frame timing: run 2 frames -> FRAME_START spacing 840000 CLK; VS low 3200 CLK starting line 490;
//     exactly 525 HS pulses per frame.
//  T3 pixel mapping: RAM model with cell (Y=2,X=5)=8'hE3, others 0 -> ROUT=7,GOUT=0,BOUT=3 exactly
//     for h 40..47, v 16..23; 0 elsewhere.
//  T4 edges: cell (X=79,Y=59)=8'hFF -> white at h 632..639, v 472..479; RGB=0 at h=640 and v=480
//     even with RD=8'hFF forced; RA never exceeds X=79/Y=59.
//  T5 blanking: RD forced 8'hFF constantly -> RGB nonzero only while active_d; RA=0 during blanking.
//  T6 reset mid-operation: assert RESET_N at v=300,h=400 for 3 CLK -> outputs return to reset values
//     immediately (async); scan restarts at (0,0), next FRAME_START 840000 CLK later.

Source files
------------

// File: rtl/vga_fb_scan_reader.sv
// Read side of the VGA framebuffer: 640x480@60 timing from the 50 MHz clock, cell-addressed scan
// of the 80x60 x 8-bit framebuffer through its synchronous read port, RGB 3:3:2 plus HS/VS.
module vga_fb_scan_reader #(
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CELL_SHIFT = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic [12:0] RA,
  input  logic [7:0]  RD,
  output logic [2:0]  ROUT,
  output logic [2:0]  GOUT,
  output logic [1:0]  BOUT,
  output logic        HS,
  output logic        VS,
  output logic        FRAME_START
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_VIS);
  localparam logic [9:0] V_ACT  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

  logic        phase;
  logic        tick;
  logic [9:0]  hcnt, vcnt;
  logic [9:0]  h_next, v_next;
  logic        h_wrap, v_wrap;
  logic        active_now, active_next;
  logic [12:0] ra_next;

  assign tick = phase;

  // NOTE: every signal driven here gets a value on every path (v_next has its default first),
  // so this stays pure combinational logic with no inferred latch.
  always_comb begin
    h_wrap      = (hcnt == H_LAST);
    v_wrap      = (vcnt == V_LAST);
    h_next      = h_wrap ? '0 : hcnt + 10'd1;
    v_next      = vcnt;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : vcnt + 10'd1;
    end
    active_now  = (hcnt < H_ACT) && (vcnt < V_ACT);
    active_next = (h_next < H_ACT) && (v_next < V_ACT);
    // Blanking addresses park at cell 0 so the RAM never sees an out-of-range X/Y.
    ra_next     = active_next ? {6'(v_next >> CELL_SHIFT), 7'(h_next >> CELL_SHIFT)} : '0;
  end

  // NOTE: all sequential state uses non-blocking assignments so each register samples the
  // pre-edge values of the others regardless of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      phase       <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      RA          <= '0;
      ROUT        <= '0;
      GOUT        <= '0;
      BOUT        <= '0;
      HS          <= 1'b1;
      VS          <= 1'b1;
      FRAME_START <= 1'b0;
    end else begin
      phase       <= ~phase;
      FRAME_START <= 1'b0;
      if (tick) begin
        hcnt        <= h_next;
        vcnt        <= v_next;
        RA          <= ra_next;
        FRAME_START <= h_wrap && v_wrap;
        // The position being replaced is the one-tick-delayed pixel whose RAM data sits on RD,
        // so colour and both syncs are derived from it and stay aligned.
        ROUT        <= active_now ? RD[7:5] : '0;
        GOUT        <= active_now ? RD[4:2] : '0;
        BOUT        <= active_now ? RD[1:0] : '0;
        HS          <= !((hcnt >= HS_BEG) && (hcnt < HS_END));
        VS          <= !((vcnt >= VS_BEG) && (vcnt < VS_END));
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_scan_reader.sv
// Bench for vga_fb_scan_reader: a reduced-geometry instance checked frame-wide and a full 640x480
// instance checked over its first lines, both against a pixel-index model of the scan.
module tb_vga_fb_scan_reader;

  typedef struct packed {
    int hv; int hfp; int hs; int hbp;
    int vv; int vfp; int vs; int vbp;
  } cfg_t;

  typedef struct packed {
    logic [12:0] ra;
    logic [7:0]  rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } vid_t;

  // Reduced geometry: 96-pixel lines (192 CLK), 40-line frames (7680 CLK).
  localparam int S_HV = 64, S_HFP = 8, S_HS = 16, S_HBP = 8;
  localparam int S_VV = 32, S_VFP = 3, S_VS = 2,  S_VBP = 3;
  localparam cfg_t C_SMALL = '{S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP};
  localparam cfg_t C_FULL  = '{640, 16, 96, 48, 480, 10, 2, 33};

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic [12:0] ra_s, ra_f;
  logic [7:0]  rd_s, rd_f;
  logic [2:0]  r_s, g_s, r_f, g_f;
  logic [1:0]  b_s, b_f;
  logic        hs_s, vs_s, fs_s, hs_f, vs_f, fs_f;

  logic [7:0]  mem [0:8191];
  bit          force_ff = 1'b0;
  int          cyc;
  int          total = 0;
  int          bad = 0;

  vga_fb_scan_reader #(
    .H_VIS(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VIS(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .CELL_SHIFT(3)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .RA(ra_s), .RD(rd_s),
    .ROUT(r_s), .GOUT(g_s), .BOUT(b_s), .HS(hs_s), .VS(vs_s), .FRAME_START(fs_s)
  );

  vga_fb_scan_reader dut_full (
    .CLK(CLK), .RESET_N(RESET_N), .RA(ra_f), .RD(rd_f),
    .ROUT(r_f), .GOUT(g_f), .BOUT(b_f), .HS(hs_f), .VS(vs_f), .FRAME_START(fs_f)
  );

  always #5 CLK = ~CLK;

  // Synchronous framebuffer read port, one CLK of latency.
  always @(posedge CLK) begin
    rd_s <= force_ff ? 8'hFF : mem[ra_s];
    rd_f <= force_ff ? 8'hFF : mem[ra_f];
  end

  // Rising CLK edges since the last reset release.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int cell_addr(cfg_t c, int h, int v);
    if (h < c.hv && v < c.vv) return (v / 8) * 128 + h / 8;
    return 0;
  endfunction

  // After n CLK edges, t = n/2 pixel ticks have happened: the scan sits at pixel t and the
  // outputs show pixel t-1 (pixel indices taken modulo the frame length).
  function automatic vid_t model(cfg_t c, int n);
    int htot, ftot, t, p, q, hq, vq;
    vid_t e;
    htot = c.hv + c.hfp + c.hs + c.hbp;
    ftot = htot * (c.vv + c.vfp + c.vs + c.vbp);
    t    = n / 2;
    p    = t % ftot;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    e.ra = 13'(cell_addr(c, p % htot, p / htot));
    if (t > 0) begin
      q  = (t - 1) % ftot;
      hq = q % htot;
      vq = q / htot;
      if (hq < c.hv && vq < c.vv) e.rgb = force_ff ? 8'hFF : mem[cell_addr(c, hq, vq)];
      e.hs = !(hq >= c.hv + c.hfp && hq < c.hv + c.hfp + c.hs);
      e.vs = !(vq >= c.vv + c.vfp && vq < c.vv + c.vfp + c.vs);
      e.fs = (n % 2 == 0) && (p == 0);
    end
    return e;
  endfunction

  always @(negedge CLK) begin : cmp
    vid_t es, ef;
    es = model(C_SMALL, cyc);
    ef = model(C_FULL, cyc);
    check("ra_small",   32'(ra_s), 32'(es.ra));
    check("rgb_small",  32'({r_s, g_s, b_s}), 32'(es.rgb));
    check("sync_small", 32'({hs_s, vs_s, fs_s}), 32'({es.hs, es.vs, es.fs}));
    check("ra_full",    32'(ra_f), 32'(ef.ra));
    check("rgb_full",   32'({r_f, g_f, b_f}), 32'(ef.rgb));
    check("sync_full",  32'({hs_f, vs_f, fs_f}), 32'({ef.hs, ef.vs, ef.fs}));
  end

  initial begin
    int   hs_fall_s, hs_rise_s, hs_fall_f, hs_rise_f;
    int   vs_fall, vs_rise, fs1, fs2, hs_pulses, fs_after;
    logic hp_s, hp_f, vp_s;

    hs_fall_s = -1; hs_rise_s = -1; hs_fall_f = -1; hs_rise_f = -1;
    vs_fall = -1; vs_rise = -1; fs1 = -1; fs2 = -1; hs_pulses = 0; fs_after = -1;
    hp_s = 1'b1; hp_f = 1'b1; vp_s = 1'b1;

    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[2 * 128 + 5]  = 8'hE3;  // cell Y=2,X=5
    mem[3 * 128 + 7]  = 8'hFF;  // last visible cell of the reduced geometry
    mem[0 * 128 + 79] = 8'h5A;  // X=79 on the first row of the full geometry
    mem[59 * 128 + 79] = 8'hFF;

    // Reset held for 10 CLK.
    #1 RESET_N = 1'b0;
    repeat (10) @(negedge CLK);
    check("rst_hs",  32'(hs_s), 32'd1);
    check("rst_vs",  32'(vs_s), 32'd1);
    check("rst_rgb", 32'({r_s, g_s, b_s}), 32'd0);
    check("rst_ra",  32'(ra_s), 32'd0);
    #1 RESET_N = 1'b1;

    // Two frames of the reduced geometry with a sparse framebuffer.
    for (int i = 0; i < 15560; i++) begin
      @(negedge CLK);
      if (hp_s && !hs_s) begin
        if (hs_fall_s < 0) hs_fall_s = cyc;
        if (fs1 >= 0 && fs2 < 0) hs_pulses++;
      end
      if (!hp_s && hs_s && hs_rise_s < 0) hs_rise_s = cyc;
      if (hp_f && !hs_f && hs_fall_f < 0) hs_fall_f = cyc;
      if (!hp_f && hs_f && hs_fall_f >= 0 && hs_rise_f < 0) hs_rise_f = cyc;
      if (vp_s && !vs_s && vs_fall < 0) vs_fall = cyc;
      if (!vp_s && vs_s && vs_fall >= 0 && vs_rise < 0) vs_rise = cyc;
      if (fs_s) begin
        if (fs1 < 0) fs1 = cyc;
        else if (fs2 < 0) fs2 = cyc;
      end
      hp_s = hs_s; hp_f = hs_f; vp_s = vs_s;
      case (cyc)
        2962: check("cell_above",   32'({r_s, g_s, b_s}), 32'h00);  // (40,15)
        3153: check("cell_left",    32'({r_s, g_s, b_s}), 32'h00);  // (39,16)
        3154: check("cell_first",   32'({r_s, g_s, b_s}), 32'hE3);  // (40,16)
        3170: check("cell_right",   32'({r_s, g_s, b_s}), 32'h00);  // (48,16)
        4512: check("cell_last",    32'({r_s, g_s, b_s}), 32'hE3);  // (47,23)
        4690: check("cell_below",   32'({r_s, g_s, b_s}), 32'h00);  // (40,24)
        6080: check("edge_corner",  32'({r_s, g_s, b_s}), 32'hFF);  // (63,31)
        6082: check("edge_h_blank", 32'({r_s, g_s, b_s}), 32'h00);  // (64,31)
        1280: check("full_x79",     32'({r_f, g_f, b_f}), 32'h5A);  // (639,0)
        1282: check("full_h640",    32'({r_f, g_f, b_f}), 32'h00);  // (640,0)
        default: ;
      endcase
    end
    check("hs_first_fall",     32'(hs_fall_s), 32'd146);
    check("hs_low_clk",        32'(hs_rise_s - hs_fall_s), 32'd32);
    check("full_hs_fall",      32'(hs_fall_f), 32'd1314);
    check("full_hs_low_clk",   32'(hs_rise_f - hs_fall_f), 32'd192);
    check("first_frame_start", 32'(fs1), 32'd7680);
    check("frame_spacing",     32'(fs2 - fs1), 32'd7680);
    check("vs_first_fall",     32'(vs_fall), 32'd6722);
    check("vs_low_clk",        32'(vs_rise - vs_fall), 32'd384);
    check("hs_per_frame",      32'(hs_pulses), 32'd40);

    // Constant all-ones read data: colour only inside the visible window.
    @(negedge CLK);
    #1 RESET_N = 1'b0;
    force_ff = 1'b1;
    repeat (3) @(negedge CLK);
    #1 RESET_N = 1'b1;
    for (int i = 0; i < 3920; i++) begin
      @(negedge CLK);
      case (cyc)
        982:  check("ff_active",   32'({r_s, g_s, b_s}), 32'hFF);  // (10,5)
        1090: begin
          check("ff_h_blank",  32'({r_s, g_s, b_s}), 32'h00);      // (64,5)
          check("ra_blank",    32'(ra_s), 32'd0);                  // scan at (65,5)
        end
        default: ;
      endcase
    end

    // Asynchronous reset in the middle of a visible line.
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    check("async_ra",    32'(ra_s), 32'd0);
    check("async_rgb",   32'({r_s, g_s, b_s}), 32'd0);
    check("async_syncs", 32'({hs_s, vs_s, fs_s}), 32'b110);
    repeat (3) @(negedge CLK);
    #1 RESET_N = 1'b1;
    for (int i = 0; i < 7700 && fs_after < 0; i++) begin
      @(negedge CLK);
      if (fs_s) fs_after = cyc;
    end
    check("restart_frame_start", 32'(fs_after), 32'd7680);

    // Pseudo-random framebuffer contents, model-checked only.
    @(negedge CLK);
    #1 RESET_N = 1'b0;
    force_ff = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge CLK);
    #1 RESET_N = 1'b1;
    repeat (4000) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
